// File: rtl/packet_pkg.sv
// Shared packet framing constants and FSM state type for the nibble packer/unpacker pair.
package packet_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] HEADER  = 4'b1111;
  localparam logic [NIBBLE_W-1:0] TRAILER = 4'b0101;

  typedef enum logic [1:0] {
    StHunt,
    StAddr,
    StData,
    StTrail
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/unpacker.sv
// Nibble-stream packet decoder: HEADER, address nibbles, data nibbles, TRAILER -> one
// decoded {addr, data} word on a valid/ready output; bad trailers drop the packet.
module unpacker
  import packet_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [3:0]            in_nibble,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  err_trailer
);

  localparam int unsigned ADDR_NIBS = ADDR_WIDTH / NIBBLE_W;
  localparam int unsigned DATA_NIBS = DATA_WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W     = $clog2(max_u(ADDR_NIBS, DATA_NIBS) + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_NIBS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_NIBS - 1);

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] data_sh;
  logic                  beat;

  // The trailer beat may only land when the output slot is free or being drained.
  assign in_ready = (state != StTrail) || !out_valid || out_ready;
  assign beat     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StHunt;
      cnt         <= '0;
      addr_sh     <= '0;
      data_sh     <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      err_trailer <= 1'b0;
    end else begin
      err_trailer <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (beat) begin
        unique case (state)
          StHunt: begin
            if (in_nibble == HEADER) begin
              state <= StAddr;
              cnt   <= '0;
            end
          end
          StAddr: begin
            addr_sh <= (addr_sh << NIBBLE_W) | ADDR_WIDTH'(in_nibble);
            if (cnt == ADDR_LAST) begin
              state <= StData;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StData: begin
            data_sh <= (data_sh << NIBBLE_W) | DATA_WIDTH'(in_nibble);
            if (cnt == DATA_LAST) begin
              state <= StTrail;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StTrail: begin
            // A good trailer overrides the drain clear above, so back-to-back has no bubble.
            if (in_nibble == TRAILER) begin
              out_addr  <= addr_sh;
              out_data  <= data_sh;
              out_valid <= 1'b1;
            end else begin
              err_trailer <= 1'b1;
            end
            state <= StHunt;
          end
          default: state <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: doc/unpacker.md
UNPACKER -- requirements
Module: unpacker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, payload data width in bits; multiple of 4.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address field width in bits; multiple of 4.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream nibble valid.
REQ-006 SHALL have port in_nibble  input  4  packet nibble, MSB-first order.
REQ-007 SHALL have port in_ready  output  1  unpacker accepts in_nibble this cycle.
REQ-008 SHALL have port out_valid  output  1  decoded packet held on out_addr/out_data.
REQ-009 SHALL have port out_ready  input  1  downstream consumes decoded packet.
REQ-010 SHALL have port out_addr  output  ADDR_WIDTH  decoded address field.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  decoded data field.
REQ-012 SHALL have port err_trailer  output  1  one-cycle pulse: packet dropped, bad trailer.

Function
REQ-013 SHALL transfer one nibble per cycle where in_valid && in_ready (a beat); no beat, no state change.
REQ-014 SHALL decode packet format: header 4'b1111, ADDR_WIDTH/4 address nibbles, DATA_WIDTH/4 data nibbles, trailer 4'b0101; 11 nibbles at defaults.
REQ-015 SHALL implement FSM states HUNT, ADDR, DATA, TRAIL; reset state HUNT.
REQ-016 SHALL in HUNT discard every beat not equal to header; header beat -> ADDR, field counter cleared.
REQ-017 SHALL in ADDR shift each beat into address register from LSB end (first nibble ends in MSBs); after ADDR_WIDTH/4 beats -> DATA.
REQ-018 SHALL in DATA shift beats likewise into data register; after DATA_WIDTH/4 beats -> TRAIL.
REQ-019 SHALL not treat 4'b1111 in ADDR/DATA as a header (no resync mid-packet).
REQ-020 SHALL in TRAIL on beat equal to 4'b0101 load out_addr/out_data, set out_valid next cycle (1-cycle latency from trailer beat), -> HUNT.
REQ-021 SHALL in TRAIL on beat not equal to 4'b0101 pulse err_trailer high exactly one cycle (next cycle), leave output untouched, -> HUNT.
REQ-022 SHALL drive in_ready high in HUNT, ADDR, DATA; in TRAIL high only when !out_valid || out_ready.
REQ-023 SHALL hold out_valid, out_addr, out_data stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid after out_valid && out_ready, unless a good trailer beat occurs same cycle, in which case out_valid stays 1 and new fields load (no bubble).
REQ-025 SHALL keep field counter width ceil(log2(max(ADDR_WIDTH,DATA_WIDTH)/4 + 1)); no wrap within a field.

Reset
REQ-026 SHALL on rst asynchronously force state HUNT, counter 0, out_valid 0, out_addr 0, out_data 0, err_trailer 0; in_ready then reads 1.
REQ-027 SHALL discard any partial packet on reset mid-operation; no out_valid or err_trailer from it after release.

Structure
REQ-028 SHALL take HEADER (4'b1111), TRAILER (4'b0101), NIBBLE_W (4) and FSM state enum from shared package packet_pkg, also imported by the packer.
REQ-029 SHALL be a single module; no sub-module.

Verification
REQ-030 SHALL cover: nibbles F,D,E,A,D,B,E,E,F,A,5 back-to-back, out_ready=1 -> out_valid 1 cycle after '5', out_addr=0xDEADBEEF, out_data=0xA.
REQ-031 SHALL cover: 3,0,7 then packet of REQ-030 -> garbage ignored, same single decode, no err_trailer.
REQ-032 SHALL cover: F,1,2,3,4,5,6,7,8,9,6 -> err_trailer one-cycle pulse, out_valid stays 0; following good packet decodes.
REQ-033 SHALL cover: out_ready=0, two packets back-to-back -> first held stable; in_ready low at second trailer until out_ready=1; second decodes without bubble.
REQ-034 SHALL cover: rst asserted after F,D,E,A then released, then full packet addr 0x00000001 data 0x3 -> only out_addr=0x00000001, out_data=0x3.
REQ-035 SHALL cover: in_valid toggled 0/1 every cycle during REQ-030 packet -> identical decode, latency counted from trailer beat.
